// File: rtl/dsd_pkg.sv
// Shared project definitions: default datapath width and the serial
// subtractor FSM state encoding.
package dsd_pkg;

   localparam int unsigned DSD_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = a - b - bin, b_out is the borrow out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic b_out
);

   always_comb begin
      diff  = a ^ b ^ bin;
      b_out = (~a & b) | (~(a ^ b) & bin);
   end

endmodule

// File: rtl/full_subtractor_serial.sv
// Bit-serial unsigned subtractor: computes a - b LSB first over WIDTH cycles
// using one full_subtractor cell, with a borrow flag for a < b.
module full_subtractor_serial
   import dsd_pkg::*;
#(
   parameter int unsigned WIDTH = DSD_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic bit_diff;
   logic bit_borrow;

   full_subtractor u_cell (
      .a     (a_q[0]),
      .b     (b_q[0]),
      .bin   (borrow_q),
      .diff  (bit_diff),
      .b_out (bit_borrow)
   );

   // busy/done are registered from the current state, so they trail the
   // state by one cycle; this yields the WIDTH+1 edge latency to done.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d      = a;
               b_d      = b;
               borrow_d = 1'b0;
               cnt_d    = '0;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            busy_d   = 1'b1;
            diff_d   = {bit_diff, diff_q[WIDTH-1:1]};
            a_d      = a_q >> 1;
            b_d      = b_q >> 1;
            borrow_d = bit_borrow;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign diff       = diff_q;
   assign borrow_out = borrow_q;

endmodule

// File: tb/tb_full_subtractor_serial.sv
// Directed and table-driven bench for full_subtractor_serial (WIDTH = 8).
module tb_full_subtractor_serial;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       busy;
   logic       done;
   logic [7:0] diff;
   logic       borrow_out;

   int checks  = 0;
   int errors  = 0;
   int overlap = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] d;
      logic       bo;
   } vec_t;

   vec_t vecs[8];

   full_subtractor_serial #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (busy === 1'b1 && done === 1'b1) overlap++;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Accept one operation, scramble a/b after capture, and check latency and result.
   task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                         input logic [7:0] exp_d, input logic exp_b, input string tag);
      int lat;
      lat = 0;
      a = ia; b = ib; start = 1'b1;
      step();
      start = 1'b0; a = ~ia; b = ~ib;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (done === 1'b1) begin
            lat = k;
            break;
         end
      end
      chk($sformatf("%s_latency", tag), lat, 9);
      chk($sformatf("%s_diff", tag), diff, exp_d);
      chk($sformatf("%s_borrow", tag), borrow_out, exp_b);
      step();
      chk($sformatf("%s_done_pulse", tag), done, 0);
      chk($sformatf("%s_diff_hold", tag), diff, exp_d);
   endtask

   initial begin
      int n_done;
      int first_k;
      int dk[3];
      logic [7:0] ra, rb;

      vecs[0] = '{a: 8'd5,   b: 8'd3,   d: 8'd2,   bo: 1'b0};
      vecs[1] = '{a: 8'd3,   b: 8'd5,   d: 8'd254, bo: 1'b1};
      vecs[2] = '{a: 8'd255, b: 8'd255, d: 8'd0,   bo: 1'b0};
      vecs[3] = '{a: 8'd0,   b: 8'd0,   d: 8'd0,   bo: 1'b0};
      vecs[4] = '{a: 8'd0,   b: 8'd1,   d: 8'd255, bo: 1'b1};
      vecs[5] = '{a: 8'd100, b: 8'd42,  d: 8'd58,  bo: 1'b0};
      vecs[6] = '{a: 8'd0,   b: 8'd255, d: 8'd1,   bo: 1'b1};
      vecs[7] = '{a: 8'd128, b: 8'd1,   d: 8'd127, bo: 1'b0};

      rst = 1'b1; start = 1'b0; a = 8'hA5; b = 8'h5A;
      step(); step();
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_diff", diff, 0);
      chk("reset_borrow", borrow_out, 0);
      chk("reset_state", 32'(dut.state_q), 0);
      rst = 1'b0;
      step();

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo, $sformatf("vec%0d", i));
      end

      // start re-asserted during SHIFT cycle 3 must be ignored
      a = 8'd20; b = 8'd7; start = 1'b1;
      step();
      start = 1'b0;
      step(); step();
      chk("ignore_busy_mid", busy, 1);
      a = 8'd1; b = 8'd200; start = 1'b1;
      step();
      start = 1'b0;
      n_done = 0; first_k = 0;
      for (int k = 4; k <= 25; k++) begin
         if (done === 1'b1) begin
            n_done++;
            if (first_k == 0) begin
               first_k = k - 1;
               chk("ignore_diff", diff, 13);
               chk("ignore_borrow", borrow_out, 0);
            end
         end
         step();
      end
      chk("ignore_done_count", n_done, 1);
      chk("ignore_latency", first_k, 9);

      // reset during SHIFT cycle 4 aborts without a done pulse
      a = 8'd77; b = 8'd9; start = 1'b1;
      step();
      start = 1'b0;
      step(); step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_diff", diff, 0);
      chk("abort_borrow", borrow_out, 0);
      chk("abort_state", 32'(dut.state_q), 0);
      n_done = 0;
      for (int k = 0; k < 15; k++) begin
         if (done === 1'b1) n_done++;
         step();
      end
      chk("abort_no_done", n_done, 0);
      run_op(8'd100, 8'd42, 8'd58, 1'b0, "post_abort");

      // start held high: three back-to-back operations
      vecs[0] = '{a: 8'd5,   b: 8'd3,   d: 8'd2,   bo: 1'b0};
      vecs[1] = '{a: 8'd3,   b: 8'd5,   d: 8'd254, bo: 1'b1};
      vecs[2] = '{a: 8'd200, b: 8'd100, d: 8'd100, bo: 1'b0};
      a = vecs[0].a; b = vecs[0].b; start = 1'b1;
      step();
      n_done = 0;
      dk[0] = 0; dk[1] = 0; dk[2] = 0;
      for (int k = 1; k <= 34; k++) begin
         step();
         if (done === 1'b1 && n_done < 3) begin
            dk[n_done] = k;
            chk($sformatf("b2b%0d_diff", n_done), diff, vecs[n_done].d);
            chk($sformatf("b2b%0d_borrow", n_done), borrow_out, vecs[n_done].bo);
            n_done++;
            if (n_done < 3) begin
               a = vecs[n_done].a; b = vecs[n_done].b;
            end else begin
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      chk("b2b_done_count", n_done, 3);
      chk("b2b_first", dk[0], 9);
      chk("b2b_second", dk[1], 19);
      chk("b2b_third", dk[2], 29);
      step(); step();

      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         run_op(ra, rb, ra - rb, (ra < rb), $sformatf("rnd%0d", i));
      end

      chk("busy_done_overlap", overlap, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
